// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a grant-hold timeout.
// The grant is presented as a binary index, a one-hot vector and a one-cold
// vector, all registered and updated together on the same edge.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; outputs at idle values, waiting for any request
// S_GRANT | idx_q owns the resource; cnt_q counts the cycles it has held it

module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [3:0]       req,
   output logic             grantValid,
   output logic [1:0]       grantIdx,
   output logic [3:0]       grantOneHot,
   output logic [3:0]       grantOneCold,
   output logic [CNT_W-1:0] holdCnt
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   // MAX_HOLD of 0 disables the timeout; otherwise rotation is due once the
   // owner has been granted for MAX_HOLD cycles (count MAX_HOLD-1).
   localparam bit               HOLD_EN  = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LIM = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic             valid_q, valid_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       onehot_q, onehot_d;
   logic [3:0]       onecold_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             win_found;
   logic [1:0]       win_idx;
   logic             do_grant;
   logic             do_idle;

   // Returns {found, index} of the first set request searching from p upward.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] cand;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         cand = p + 2'(i);
         if (r[cand]) begin
            res = {1'b1, cand};
         end
      end
      return res;
   endfunction

   // Round-robin winner among the currently sampled requests.
   always_comb begin
      {win_found, win_idx} = rr_pick(req, ptr_q);
   end

   // Next-state: release/handoff first, then forced rotation, else hold.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      valid_d  = valid_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
      cnt_d    = cnt_q;
      do_grant = 1'b0;
      do_idle  = 1'b0;

      case (state_q)
         S_IDLE: begin
            do_grant = win_found;
         end
         S_GRANT: begin
            if (!req[idx_q]) begin
               do_grant = win_found;
               do_idle  = !win_found;
            end else if (HOLD_EN && (cnt_q >= HOLD_LIM) && |(req & ~onehot_q)) begin
               // ptr_q is owner+1, so the owner is searched last and loses
               do_grant = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            do_idle = 1'b1;
         end
      endcase

      if (do_grant) begin
         state_d  = S_GRANT;
         valid_d  = 1'b1;
         idx_d    = win_idx;
         onehot_d = 4'b0001 << win_idx;
         ptr_d    = win_idx + 2'd1;
         cnt_d    = '0;
      end else if (do_idle) begin
         state_d  = S_IDLE;
         valid_d  = 1'b0;
         idx_d    = 2'd0;
         onehot_d = 4'h0;
         cnt_d    = '0;
      end
   end

   // State and output registers; reset forces idle outputs immediately.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= S_IDLE;
         ptr_q     <= 2'd0;
         valid_q   <= 1'b0;
         idx_q     <= 2'd0;
         onehot_q  <= 4'h0;
         onecold_q <= 4'hF;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         onehot_q  <= onehot_d;
         onecold_q <= ~onehot_d;
         cnt_q     <= cnt_d;
      end
   end

   assign grantValid   = valid_q;
   assign grantIdx     = idx_q;
   assign grantOneHot  = onehot_q;
   assign grantOneCold = onecold_q;
   assign holdCnt      = cnt_q;

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with a grant-hold timeout; shares one resource among four clients.
- Grant is presented as a binary index, one-hot vector and one-cold vector. The one-hot and one-cold encodings match the 2-to-4 decoder output format, so downstream select and enable logic connects directly.
- Sits between requesting engines and a shared bus or port; registered outputs only.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold grant while another request is pending. 0 = unlimited. Legal range 0..255.
- CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- req  in  4  request vector, bit i = requester i. Held high for the entire ownership.
- grantValid  out  1  a grant is active.
- grantIdx  out  2  binary index of current owner; 0 when idle.
- grantOneHot  out  4  one-hot grant; 4'h0 when idle.
- grantOneCold  out  4  bitwise inverse of grantOneHot; 4'hF when idle.
- holdCnt  out  CNT_W  cycles current owner has held grant, starting at 0 on the grant cycle.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - grantValid=0, grantIdx=0, grantOneHot=4'h0, grantOneCold=4'hF, holdCnt=0.
  - Priority pointer ptr=0; state IDLE.
- Priority: search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set req bit wins.
- On every new grant to index k: ptr <= k+1 mod 4, with wrap 3 -> 0. holdCnt <= 0.
- All outputs are registered and update together on the same edge. grantOneCold == ~grantOneHot at all times.
- IDLE:
  - If req != 0, grant the winner on the next edge and move to GRANT.
  - Latency is 1 cycle from req sampled high to grantValid high.
  - Otherwise stay in IDLE.
- GRANT (owner k):
  - If req[k]=0 (release): if other requests are pending, hand off to the round-robin winner on the same edge (zero idle bubble), staying in GRANT. Else go to IDLE with outputs at idle values.
  - Else if MAX_HOLD != 0, holdCnt >= MAX_HOLD-1, and (req & ~onehot(k)) != 0: forced rotation. Grant the next round-robin winner, which always differs from k because ptr = k+1.
  - Else hold: holdCnt increments, saturating at 2^CNT_W-1.
- Timeout with no other pending request: the owner keeps the grant and holdCnt keeps counting (saturating). Rotation happens on the first cycle another request appears.
- Simultaneous release of owner and new requests: handled as release with handoff; the requester set is sampled on that edge.
- A requester that drops req before being granted is never granted.
- Owner re-raising req after release competes normally; it has lowest priority because ptr = k+1.
- Reset mid-grant: outputs go to idle values immediately (async). After reset, ptr=0.
- Only values 0001/0010/0100/1000 or 0000 ever appear on grantOneHot.

Test Plan:
- Reset with req=4'hF held -> during reset grantOneHot=4'h0, grantOneCold=4'hF. Cycle 1 after release: grantIdx=0, grantOneHot=4'h1, grantOneCold=4'hE.
- req=4'hF, each owner drops req for 1 cycle after 3 cycles of grant -> grant order 0,1,2,3,0. Handoff without an idle cycle; holdCnt restarts at 0 on each grant.
- MAX_HOLD=4, req=4'b0011 held constantly -> owner 0 for 4 cycles (holdCnt 0..3), then owner 1 for 4, then owner 0; grantOneHot alternates 4'h1/4'h2.
- MAX_HOLD=4, only req[2] high for 20 cycles -> grantIdx=2 throughout, holdCnt reaches 19. Raise req[0] -> owner 0 granted next edge.
- Owner 3 releases while req=4'b0001 and ptr=0 -> grantIdx=0, ptr wraps to 1. Then req=0 -> grantValid=0, grantOneCold=4'hF next cycle.
- Assert rstN=0 mid-grant (owner 2, holdCnt=5) -> outputs idle asynchronously. After release with req=4'b0100 -> grantIdx=2 after 1 cycle, holdCnt=0.
